// File: rtl/switch_debounce_pair.sv
// Two-channel push-button conditioner: synchronize, debounce, press pulses, LED drives.
// Latency: DEBOUNCE_LIMIT+1 clock edges from a stable raw change to o_Switch_n / o_Press_n.
// Backpressure: none; outputs are free-running levels and single-cycle pulses.
//
// Ports:
//   i_Clk, i_Reset          clock (rising edge) and asynchronous active-high reset
//   i_Switch_1, i_Switch_2  raw, bouncy, asynchronous switch inputs
//   o_Switch_1, o_Switch_2  debounced levels
//   o_Press_1, o_Press_2    one-cycle pulse on each debounced 0->1
//   o_LED_1                 o_Switch_1 AND o_Switch_2
//   o_LED_2                 toggles on every switch 1 press

// Single debounce channel.
// Latency: DEBOUNCE_LIMIT+1 edges from raw change to level/press.
// Backpressure: none.
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   raw       raw switch input
//   level     debounced level (decoded from the registered FSM state)
//   press     registered one-cycle pulse on a debounced rise
//   rise      combinational: press will assert after the coming edge
module switch_debounce_chan #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);

  typedef enum logic [1:0] {
    STABLE_LOW,
    COUNT_HIGH,
    STABLE_HIGH,
    COUNT_LOW
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sync1;

  // sync1 is the first synchronizer stage. The FSM state/counter registers
  // sample sync1 on the following edge and so act as the second stage; this
  // lets the first counted edge coincide with the second synchronizer edge,
  // which keeps the overall latency at DEBOUNCE_LIMIT+1 edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      state <= STABLE_LOW;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      press <= rise;
    end
  end

  // Counter idles at zero; any sample that matches the current debounced
  // level aborts a count. The count stops at LAST, so it cannot wrap.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    rise      = 1'b0;
    case (state)
      STABLE_LOW: begin
        if (sync1) begin
          state_nxt = COUNT_HIGH;
          cnt_nxt   = CW'(1);
        end
      end
      COUNT_HIGH: begin
        if (!sync1) begin
          state_nxt = STABLE_LOW;
        end else if (cnt == LAST) begin
          state_nxt = STABLE_HIGH;
          rise      = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STABLE_HIGH: begin
        if (!sync1) begin
          state_nxt = COUNT_LOW;
          cnt_nxt   = CW'(1);
        end
      end
      COUNT_LOW: begin
        if (sync1) begin
          state_nxt = STABLE_HIGH;
        end else if (cnt == LAST) begin
          state_nxt = STABLE_LOW;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = STABLE_LOW;
    endcase
  end

  assign level = (state == STABLE_HIGH) || (state == COUNT_LOW);

endmodule

module switch_debounce_pair #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch_1,
  input  logic i_Switch_2,
  output logic o_Switch_1,
  output logic o_Switch_2,
  output logic o_Press_1,
  output logic o_Press_2,
  output logic o_LED_1,
  output logic o_LED_2
);

  logic rise_1;
  logic rise_2;

  switch_debounce_chan #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_chan_1 (
    .clk   (i_Clk),
    .rst   (i_Reset),
    .raw   (i_Switch_1),
    .level (o_Switch_1),
    .press (o_Press_1),
    .rise  (rise_1)
  );

  switch_debounce_chan #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_chan_2 (
    .clk   (i_Clk),
    .rst   (i_Reset),
    .raw   (i_Switch_2),
    .level (o_Switch_2),
    .press (o_Press_2),
    .rise  (rise_2)
  );

  // Both levels are decoded from registered state, so the AND adds no latency.
  assign o_LED_1 = o_Switch_1 & o_Switch_2;

  // Toggle on the edge that registers the switch 1 press pulse.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_LED_2 <= 1'b0;
    end else if (rise_1) begin
      o_LED_2 <= ~o_LED_2;
    end
  end

endmodule

// File: tb/tb_switch_debounce_pair.sv
module tb_switch_debounce_pair;

  localparam int L = 4;

  logic clk = 1'b0;
  logic rst;
  logic sw1, sw2;
  logic o_sw1, o_sw2, o_pr1, o_pr2, o_led1, o_led2;

  switch_debounce_pair #(.DEBOUNCE_LIMIT(L)) dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .i_Switch_1 (sw1),
    .i_Switch_2 (sw2),
    .o_Switch_1 (o_sw1),
    .o_Switch_2 (o_sw2),
    .o_Press_1  (o_pr1),
    .o_Press_2  (o_pr2),
    .o_LED_1    (o_led1),
    .o_LED_2    (o_led2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [5:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected debounced state, updated by hand at each directed step.
  bit s1, s2, l2;

  logic [5:0] obs;
  assign obs = {o_sw1, o_sw2, o_pr1, o_pr2, o_led1, o_led2};

  function automatic logic [5:0] ev(input bit p1, input bit p2);
    return {s1, s2, p1, p2, s1 & s2, l2};
  endfunction

  task automatic push(input string tag, input logic [5:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    e = sb.pop_front();
    n_cmp++;
    assert (obs === e.v)
    else begin
      n_bad++;
      $error("FAIL %s: observed {sw1,sw2,pr1,pr2,led1,led2}=%b expected %b",
             e.tag, obs, e.v);
    end
  endtask

  // Expect v after the next rising edge.
  task automatic tick(input string tag, input logic [5:0] v);
    push(tag, v);
    @(posedge clk);
    #1;
    compare();
  endtask

  // Expect v right now, without waiting for an edge.
  task automatic now_chk(input string tag, input logic [5:0] v);
    push(tag, v);
    compare();
  endtask

  task automatic hold(input string tag, input int n);
    repeat (n) tick(tag, ev(1'b0, 1'b0));
  endtask

  // Drive a clean level change and expect it on the (L+1)th edge.
  task automatic debounce(input int ch, input bit val, input string tag);
    if (ch == 1) sw1 = val;
    else         sw2 = val;
    hold(tag, L);
    if (ch == 1) s1 = val;
    else         s2 = val;
    if (ch == 1 && val) l2 = ~l2;
    tick(tag, ev(ch == 1 && val, ch == 2 && val));
    tick(tag, ev(1'b0, 1'b0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sw1 = 1'b0;
    sw2 = 1'b0;
    s1  = 1'b0;
    s2  = 1'b0;
    l2  = 1'b0;
    #1;
    now_chk("reset_async", 6'b0);
    hold("reset_held", 3);
    rst = 1'b0;
    hold("idle", 20);

    // Clean presses on switch 1; second press toggles LED_2 back.
    debounce(1, 1'b1, "press1_a");
    debounce(1, 1'b0, "rel1_a");
    debounce(1, 1'b1, "press1_b");
    debounce(1, 1'b0, "rel1_b");

    // Bouncing switch 2, then a steady rise.
    sw2 = 1'b1; hold("bounce", 3);
    sw2 = 1'b0; hold("bounce", 1);
    sw2 = 1'b1; hold("bounce", 2);
    sw2 = 1'b0; hold("bounce", 1);
    debounce(2, 1'b1, "bounce_final");

    // Both high drives LED_1; releasing switch 1 clears it with no pulse.
    debounce(1, 1'b1, "both_high");
    debounce(1, 1'b0, "rel1_led1");

    // Glitch of L-1 cycles is filtered.
    sw1 = 1'b1; hold("glitch3", 3);
    sw1 = 1'b0; hold("glitch3", 6);

    // Glitch of exactly L cycles flips the level, then it debounces back.
    sw1 = 1'b1; hold("glitch4", 4);
    sw1 = 1'b0;
    s1 = 1'b1;
    l2 = ~l2;
    tick("glitch4_rise", ev(1'b1, 1'b0));
    hold("glitch4_high", 3);
    s1 = 1'b0;
    tick("glitch4_fall", ev(1'b0, 1'b0));
    hold("glitch4_low", 2);

    // Reset during COUNT_HIGH on switch 1 with switch 2 debounced high.
    sw1 = 1'b1;
    hold("cnt_high", 2);
    #2;
    rst = 1'b1;
    #1;
    s1 = 1'b0; s2 = 1'b0; l2 = 1'b0;
    now_chk("rst_in_count", 6'b0);
    hold("rst_hold_a", 2);
    rst = 1'b0;
    hold("after_rst_a", L);
    s1 = 1'b1; s2 = 1'b1; l2 = ~l2;
    tick("rst_rerise_a", ev(1'b1, 1'b1));
    tick("rst_rerise_a", ev(1'b0, 1'b0));

    // Reset while switch 1 is debounced high; it re-presses after release.
    #2;
    rst = 1'b1;
    sw2 = 1'b0;
    #1;
    s1 = 1'b0; s2 = 1'b0; l2 = 1'b0;
    now_chk("rst_while_high", 6'b0);
    hold("rst_hold_b", 2);
    rst = 1'b0;
    hold("after_rst_b", L);
    s1 = 1'b1; l2 = ~l2;
    tick("rst_rerise_b", ev(1'b1, 1'b0));
    hold("rst_rerise_b", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
